// File: rtl/lut_neuron_pkg.sv
// rtl/lut_neuron_pkg.sv - shared types and helpers for the LUT neuron array
package lut_neuron_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // A select port is at least one bit wide even for a single neuron.
    function automatic int neuron_sel_w(input int num_neurons);
        return (num_neurons > 1) ? $clog2(num_neurons) : 1;
    endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// rtl/lut_neuron_ram.sv - per-neuron truth table, sync write / async read (LUT_NEURON_READBACK_EN adds a second read port)
module lut_neuron_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
`ifdef LUT_NEURON_READBACK_EN
    ,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2
`endif
);

    // Contents survive reset on purpose: weights stay loaded across a pipeline flush.
    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

`ifdef LUT_NEURON_READBACK_EN
    assign rdata2 = mem[raddr2];
`endif

endmodule

// File: rtl/lut_neuron_array.sv
// rtl/lut_neuron_array.sv - two-stage pipelined array of runtime-loadable truth-table neurons (LUT_NEURON_READBACK_EN)
module lut_neuron_array
    import lut_neuron_pkg::*;
#(
    parameter int  NUM_NEURONS = 4,
    parameter int  FANIN       = 3,
    parameter int  IN_BITS     = 2,
    parameter int  OUT_BITS    = 2,
    localparam int ADDR_W      = FANIN * IN_BITS,
    localparam int TABLE_DEPTH = 2 ** ADDR_W,
    localparam int SEL_W       = neuron_sel_w(NUM_NEURONS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NEURONS*ADDR_W-1:0]   in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                            cfg_start,
    output logic                            cfg_ready,
    input  logic                            cfg_we,
    input  logic [SEL_W-1:0]                cfg_neuron,
    input  logic [ADDR_W-1:0]               cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_wdata,
    input  logic                            cfg_done
`ifdef LUT_NEURON_READBACK_EN
    ,
    input  logic                            cfg_re,
    output logic [OUT_BITS-1:0]             cfg_rdata,
    output logic                            cfg_rvalid
`endif
);

    state_t state, next_state;

    logic                            s1_valid;
    logic [NUM_NEURONS*ADDR_W-1:0]   s1_data;
    logic [NUM_NEURONS*OUT_BITS-1:0] lut_out;
    logic                            adv;
    logic                            accept;
    logic                            sel_ok;
    logic                            wr_en;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = (state == RUN) && adv;
    assign accept    = in_valid && in_ready;
    assign cfg_ready = (state == LOAD);
    assign sel_ok    = 32'(cfg_neuron) < NUM_NEURONS;
    assign wr_en     = cfg_we && (state == LOAD) && sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (cfg_start) next_state = DRAIN;
            DRAIN:   if (!s1_valid && !out_valid) next_state = LOAD;
            LOAD:    if (cfg_done) next_state = RUN;
            default: next_state = LOAD;
        endcase
    end

    // Both stages move in lockstep; a stalled output freezes the whole pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            s1_valid  <= accept;
            out_valid <= s1_valid;
            if (accept) begin
                s1_data <= in_data;
            end
            if (s1_valid) begin
                out_data <= lut_out;
            end
        end
    end

`ifdef LUT_NEURON_READBACK_EN
    logic [OUT_BITS-1:0] rb_data [NUM_NEURONS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rvalid <= 1'b0;
            cfg_rdata  <= '0;
        end else begin
            cfg_rvalid <= cfg_re;
            cfg_rdata  <= (cfg_re && (state == LOAD) && sel_ok) ? rb_data[cfg_neuron] : '0;
        end
    end
`endif

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
        lut_neuron_ram #(
            .DEPTH (TABLE_DEPTH),
            .AW    (ADDR_W),
            .DW    (OUT_BITS)
        ) u_ram (
            .clk    (clk),
            .we     (wr_en && (cfg_neuron == SEL_W'(n))),
            .waddr  (cfg_addr),
            .wdata  (cfg_wdata),
            .raddr  (s1_data[n*ADDR_W +: ADDR_W]),
            .rdata  (lut_out[n*OUT_BITS +: OUT_BITS])
`ifdef LUT_NEURON_READBACK_EN
            ,
            .raddr2 (cfg_addr),
            .rdata2 (rb_data[n])
`endif
        );
    end

endmodule

// File: tb/tb_lut_neuron_array.sv
// tb/tb_lut_neuron_array.sv - directed self-checking bench for lut_neuron_array (LUT_NEURON_READBACK_EN)
module tb_lut_neuron_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        cfg_start;
    logic        cfg_ready;
    logic        cfg_we;
    logic [1:0]  cfg_neuron;
    logic [5:0]  cfg_addr;
    logic [1:0]  cfg_wdata;
    logic        cfg_done;
`ifdef LUT_NEURON_READBACK_EN
    logic        cfg_re;
    logic [1:0]  cfg_rdata;
    logic        cfg_rvalid;
`endif

    int vectors = 0;
    int errors  = 0;

    // Beat stimuli ({n3,n2,n1,n0} addresses) and their hand-computed results.
    localparam logic [23:0] BEAT_A = {6'h3F, 6'h00, 6'h00, 6'h05};
    localparam logic [23:0] BEAT_B = {6'h01, 6'h01, 6'h01, 6'h01};
    localparam logic [23:0] BEAT_C = {6'h2A, 6'h2A, 6'h2A, 6'h2A};
    localparam logic [7:0]  RES_A  = 8'h5E;
    localparam logic [7:0]  RES_B  = 8'h39;
    localparam logic [7:0]  RES_C  = 8'h93;

    always #5 clk = ~clk;

    lut_neuron_array dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_start  (cfg_start),
        .cfg_ready  (cfg_ready),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_done   (cfg_done)
`ifdef LUT_NEURON_READBACK_EN
        ,
        .cfg_re     (cfg_re),
        .cfg_rdata  (cfg_rdata),
        .cfg_rvalid (cfg_rvalid)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] n, input logic [5:0] a, input logic [1:0] d, input logic done);
        cfg_we     = 1'b1;
        cfg_neuron = n;
        cfg_addr   = a;
        cfg_wdata  = d;
        cfg_done   = done;
        tick();
        cfg_we     = 1'b0;
        cfg_done   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cfg_start = 1'b0; cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0;
        cfg_wdata = '0; cfg_done = 1'b0;
`ifdef LUT_NEURON_READBACK_EN
        cfg_re = 1'b0;
`endif
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
`ifdef LUT_NEURON_READBACK_EN
        chk("rst_cfg_rvalid", 32'(cfg_rvalid), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Table load; the final write shares its cycle with cfg_done.
        wr(2'd0, 6'h05, 2'b10, 1'b0); wr(2'd1, 6'h00, 2'b11, 1'b0);
        wr(2'd2, 6'h00, 2'b01, 1'b0); wr(2'd3, 6'h3F, 2'b01, 1'b0);
        wr(2'd0, 6'h01, 2'b01, 1'b0); wr(2'd1, 6'h01, 2'b10, 1'b0);
        wr(2'd2, 6'h01, 2'b11, 1'b0); wr(2'd3, 6'h01, 2'b00, 1'b0);
        wr(2'd0, 6'h2A, 2'b11, 1'b0); wr(2'd1, 6'h2A, 2'b00, 1'b0);
        wr(2'd2, 6'h2A, 2'b01, 1'b0); wr(2'd3, 6'h2A, 2'b10, 1'b1);
        chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("run_in_ready",  32'(in_ready),  32'd1);

        // Single beat, latency two cycles.
        out_ready = 1'b1; in_valid = 1'b1; in_data = BEAT_A;
        tick();
        in_valid = 1'b0;
        chk("lat1_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat2_out_valid", 32'(out_valid), 32'd1);
        chk("lat2_out_data",  32'(out_data),  32'(RES_A));
        chk("lat2_n0",        32'(out_data[1:0]), 32'd2);
        chk("lat2_n3",        32'(out_data[7:6]), 32'd1);
        tick();
        chk("lat3_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: two beats enter, third waits, then all drain in order.
        out_ready = 1'b0; in_valid = 1'b1; in_data = BEAT_A;
        tick();
        in_data = BEAT_B;
        tick();
        in_data = BEAT_C;
        chk("bp_in_ready",  32'(in_ready),  32'd0);
        chk("bp_out_data",  32'(out_data),  32'(RES_A));
        tick();
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_data",  32'(out_data),  32'(RES_A));
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_out_b", 32'(out_data), 32'(RES_B));
        tick();
        chk("bp_out_c",   32'(out_data),  32'(RES_C));
        chk("bp_c_valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // A write while running must be dropped.
        wr(2'd0, 6'h05, 2'b00, 1'b0);

        // cfg_start with a same-cycle accept, then drain under backpressure.
        out_ready = 1'b0; in_valid = 1'b1; in_data = BEAT_A; cfg_start = 1'b1;
        tick();
        in_valid = 1'b0; cfg_start = 1'b0;
        chk("drain_in_ready",  32'(in_ready),  32'd0);
        chk("drain_cfg_ready", 32'(cfg_ready), 32'd0);
        wr(2'd0, 6'h05, 2'b01, 1'b0);
        chk("drain_out_valid", 32'(out_valid), 32'd1);
        chk("drain_out_data",  32'(out_data),  32'(RES_A));
        tick();
        chk("drain_hold_ready", 32'(cfg_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("drain_consumed", 32'(out_valid), 32'd0);
        chk("drain_last_cyc", 32'(cfg_ready), 32'd0);
        tick();
        chk("drain_to_load", 32'(cfg_ready), 32'd1);
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        in_valid = 1'b1; in_data = BEAT_A;
        tick();
        in_valid = 1'b0;
        tick();
        chk("dropped_writes", 32'(out_data), 32'(RES_A));

        // Asynchronous reset mid-stream; tables are retained.
        out_ready = 1'b0; in_valid = 1'b1; in_data = BEAT_C;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_data",  32'(out_data),  32'd0);
        chk("async_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        in_valid = 1'b1; in_data = BEAT_B;
        tick();
        in_valid = 1'b0;
        tick();
        chk("retained_b", 32'(out_data), 32'(RES_B));

`ifdef LUT_NEURON_READBACK_EN
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick(); tick();
        chk("rb_in_load", 32'(cfg_ready), 32'd1);
        wr(2'd1, 6'h2A, 2'b11, 1'b0);
        cfg_re = 1'b1; cfg_neuron = 2'd1; cfg_addr = 6'h2A;
        tick();
        chk("rb_rvalid", 32'(cfg_rvalid), 32'd1);
        chk("rb_rdata",  32'(cfg_rdata),  32'd3);
        cfg_neuron = 2'd0; cfg_addr = 6'h05;
        tick();
        cfg_re = 1'b0;
        chk("rb_rdata_n0", 32'(cfg_rdata), 32'd2);
        tick();
        chk("rb_rvalid_off", 32'(cfg_rvalid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
